// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: small register bank with ALU write-back, two-operand fetch FSM and valid/ready output.
// Optional macro OPERAND_FETCH_BYPASS_EN forwards a same-edge write-back into the operand being read.
module operand_fetch_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     src_a,
    input  logic [AW-1:0]     src_b,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_A  = 2'd1,
        READ_B  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     idx_a;
    logic [AW-1:0]     idx_b;
    logic              wr_ok_c;

    assign wr_ok_c = wr_en && (32'(wr_addr) < NREGS);

    // Value captured for a read of index idx; out-of-range indices read as zero.
    function automatic logic [DATA_W-1:0] fetch_val(input logic [AW-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(idx) == i) v = regs[i];
        end
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wr_ok_c && (wr_addr == idx)) v = wr_data;
`endif
        return v;
    endfunction

    // Write-back port, active in every FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok_c) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Fetch FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx_a     <= '0;
            idx_b     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_a     <= src_a;
                        idx_b     <= src_b;
                        state     <= READ_A;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                READ_A: begin
                    op_a  <= fetch_val(idx_a);
                    state <= READ_B;
                end
                READ_B: begin
                    op_b     <= fetch_val(idx_b);
                    op_valid <= 1'b1;
                    state    <= PRESENT;
                end
                PRESENT: begin
                    // Operands are a snapshot: held until the ALU accepts them.
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    op_valid  <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: table-driven fetches plus hand-written multi-cycle sequences.
module tb_operand_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    // Full fetch from IDLE: checks latency, operands and the return to IDLE.
    task automatic fetch(input logic [1:0] a, input logic [1:0] b,
                         input logic [7:0] ea, input logic [7:0] eb, input string tag);
        int n;
        req_valid = 1'b1; src_a = a; src_b = b;
        step();
        req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!op_valid && n < 8) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        check({tag, "_op_a"}, 32'(op_a), 32'(ea));
        check({tag, "_op_b"}, 32'(op_b), 32'(eb));
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(op_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int  accept_cyc [$];
        int  cyc;
        logic prev_rdy;

        vecs[0] = '{a: 2'd1, b: 2'd2, exp_a: 8'h3C, exp_b: 8'hA5};
        vecs[1] = '{a: 2'd2, b: 2'd1, exp_a: 8'hA5, exp_b: 8'h3C};
        vecs[2] = '{a: 2'd0, b: 2'd3, exp_a: 8'h11, exp_b: 8'h5A};
        vecs[3] = '{a: 2'd3, b: 2'd3, exp_a: 8'h5A, exp_b: 8'h5A};
        vecs[4] = '{a: 2'd0, b: 2'd0, exp_a: 8'h11, exp_b: 8'h11};

        rst = 1'b1; req_valid = 1'b0; src_a = '0; src_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; op_ready = 1'b0;
        #12;
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_op_a", 32'(op_a), 32'h00);
        check("rst_op_b", 32'(op_b), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        write_reg(2'd0, 8'h11);
        write_reg(2'd1, 8'h3C);
        write_reg(2'd2, 8'hA5);
        write_reg(2'd3, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            fetch(vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle while presenting operands.
        req_valid = 1'b1; src_a = 2'd1; src_b = 2'd2;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("pre_rst_valid", 32'(op_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(op_valid), 32'd0);
        check("async_rst_op_a", 32'(op_a), 32'h00);
        check("async_rst_op_b", 32'(op_b), 32'h00);
        check("async_rst_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        step();
        check("async_rst_ready", 32'(req_ready), 32'd1);

        // Write-back to reg0 on the READ_A edge.
        write_reg(2'd0, 8'h11);
        req_valid = 1'b1; src_a = 2'd0; src_b = 2'd3;
        step();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        check("coll_valid", 32'(op_valid), 32'd1);
`ifdef OPERAND_FETCH_BYPASS_EN
        check("coll_op_a", 32'(op_a), 32'h77);
`else
        check("coll_op_a", 32'(op_a), 32'h11);
`endif
        check("coll_op_b", 32'(op_b), 32'h00);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        fetch(2'd0, 2'd0, 8'h77, 8'h77, "coll_after");

        // Backpressure with writes during PRESENT.
        write_reg(2'd1, 8'h3C);
        write_reg(2'd2, 8'hA5);
        req_valid = 1'b1; src_a = 2'd1; src_b = 2'd2;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF;
            step();
            check($sformatf("bp%0d_valid", i), 32'(op_valid), 32'd1);
            check($sformatf("bp%0d_op_a", i), 32'(op_a), 32'h3C);
            check($sformatf("bp%0d_op_b", i), 32'(op_b), 32'hA5);
            check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
        end
        wr_en = 1'b0;
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        check("bp_release_valid", 32'(op_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        fetch(2'd1, 2'd2, 8'hFF, 8'hA5, "bp_after");

        // Same source, back-to-back with requests and op_ready held high.
        write_reg(2'd2, 8'h5A);
        op_ready = 1'b1; req_valid = 1'b1; src_a = 2'd2; src_b = 2'd2;
        cyc = 0;
        for (int i = 0; i < 9; i++) begin
            prev_rdy = req_ready;
            step();
            cyc++;
            if (prev_rdy) accept_cyc.push_back(cyc);
            if (op_valid) begin
                check($sformatf("b2b_c%0d_op_a", cyc), 32'(op_a), 32'h5A);
                check($sformatf("b2b_c%0d_op_b", cyc), 32'(op_b), 32'h5A);
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(accept_cyc.size()), 32'd3);
        if (accept_cyc.size() >= 2)
            check("b2b_spacing", 32'(accept_cyc[1] - accept_cyc[0]), 32'd4);
        for (int i = 0; i < 4; i++) step();
        op_ready = 1'b0;
        check("b2b_idle", 32'(req_ready), 32'd1);

        // Reset while in READ_B clears the bank.
        write_reg(2'd1, 8'h3C);
        req_valid = 1'b1; src_a = 2'd1; src_b = 2'd1;
        step();
        req_valid = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        check("rstb_valid", 32'(op_valid), 32'd0);
        check("rstb_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        step();
        fetch(2'd1, 2'd1, 8'h00, 8'h00, "rstb_reg1");
        fetch(2'd2, 2'd0, 8'h00, 8'h00, "rstb_reg20");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
